// File: rtl/bus_req_pkg.sv
// Shared definitions for the bus requester agent and the arbiter bench models.
//   state_e      : 2-bit FSM encoding IDLE/REQ/XFER/REL
//   DEF_*        : default widths and watchdog period
//   cnt_width()  : counter width able to hold 0..v-1 (minimum 1)
package bus_req_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_REL  = 2'd3
  } state_e;

  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_LEN_W       = 8;
  localparam int unsigned DEF_TIMEOUT_CYC = 64;

  function automatic int unsigned cnt_width(input int unsigned v);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 32; i++)
      if ((64'd1 << w) < 64'(v)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/bus_req_wdog.sv
// Request watchdog: counts cycles while enabled, saturating at TIMEOUT_CYC-1.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : synchronous clear (wins over count)
//   cnt_en_i   : advance the count this cycle
//   term_o     : count has reached TIMEOUT_CYC-1
module bus_req_wdog
  import bus_req_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic cnt_en_i,
  output logic term_o
);

  localparam int unsigned W = cnt_width(TIMEOUT_CYC);
  localparam logic [W-1:0] TERM = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                        cnt_d = '0;
    else if (cnt_en_i && cnt_q != TERM) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign term_o = (cnt_q == TERM);

endmodule

// File: rtl/bus_requester.sv
// Client-side agent for a two-input request/grant arbiter. Accepts a burst
// command (cmd_len_i+1 beats), raises req_o, streams source beats straight
// onto the bus while granted, then drops req_o for one cycle (REL).
// Grant loss mid-burst stalls the stream; req_o is held until it resumes.
// Optional watchdog (macro BUS_REQ_TIMEOUT_EN) aborts a request that is never
// granted within TIMEOUT_CYC cycles; without it err_timeout_o is tied 0.
//   clk, rst_n           : clock, async active-low reset
//   cmd_valid_i/ready_o  : burst command handshake, cmd_len_i = beats-1
//   src_data_i/valid_i   : local beat source, src_ready_o consumes
//   req_o / gnt_i        : arbiter request / grant
//   bus_data_o/valid_o   : beat to shared bus (zero-latency pass-through)
//   busy_o               : not IDLE
//   done_o               : pulse on last beat
//   err_timeout_o        : pulse on watchdog abort
module bus_requester
  import bus_req_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned LEN_W       = DEF_LEN_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  output logic              cmd_ready_o,
  input  logic [DATA_W-1:0] src_data_i,
  input  logic              src_valid_i,
  output logic              src_ready_o,
  output logic              req_o,
  input  logic              gnt_i,
  output logic [DATA_W-1:0] bus_data_o,
  output logic              bus_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_timeout_o
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             fire, last, timeout;

  // Beats move only in XFER; a grant seen in IDLE/REQ/REL never transfers.
  assign fire = (state_q == ST_XFER) && gnt_i && src_valid_i;
  // Compare before incrementing so len_q = max yields 2^LEN_W beats without wrap.
  assign last = fire && (cnt_q == len_q);

`ifdef BUS_REQ_TIMEOUT_EN
  logic wdog_term;

  // Held clear outside REQ, so every REQ entry starts from zero.
  bus_req_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q != ST_REQ),
    .cnt_en_i ((state_q == ST_REQ) && !gnt_i),
    .term_o   (wdog_term)
  );

  // A grant on the terminal cycle takes priority over the abort.
  assign timeout = (state_q == ST_REQ) && !gnt_i && wdog_term;
`else
  assign timeout = 1'b0;
`endif

  // State and burst registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end

  // Next state
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE:
        if (cmd_valid_i) begin
          state_d = ST_REQ;
          len_d   = cmd_len_i;
          cnt_d   = '0;
        end
      ST_REQ:
        if (gnt_i)        state_d = ST_XFER;
        else if (timeout) state_d = ST_IDLE;
      ST_XFER:
        if (last)         state_d = ST_REL;
        else if (fire)    cnt_d   = cnt_q + 1'b1;
      ST_REL:             state_d = ST_IDLE;
      default:            state_d = ST_IDLE;
    endcase
  end

  // Outputs (combinational from state and live inputs)
  always_comb begin
    // rst_n term keeps cmd_ready low while reset is held even though state is IDLE.
    cmd_ready_o   = (state_q == ST_IDLE) && rst_n;
    req_o         = (state_q == ST_REQ) || (state_q == ST_XFER);
    src_ready_o   = (state_q == ST_XFER) && gnt_i;
    bus_valid_o   = fire;
    bus_data_o    = src_data_i;
    busy_o        = (state_q != ST_IDLE);
    done_o        = last;
    err_timeout_o = timeout;
  end

endmodule

// File: tb/tb_bus_requester.sv
module tb_bus_requester;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;
  localparam int TOC    = 8;

  logic              clk, rst_n;
  logic              cmd_valid, cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] src_data, bus_data;
  logic              src_valid, src_ready;
  logic              req, gnt, bus_valid, busy, done, err_timeout;

  int n_chk = 0;
  int n_err = 0;

  bus_requester #(.DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT_CYC(TOC)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_len_i(cmd_len), .cmd_ready_o(cmd_ready),
    .src_data_i(src_data), .src_valid_i(src_valid), .src_ready_o(src_ready),
    .req_o(req), .gnt_i(gnt),
    .bus_data_o(bus_data), .bus_valid_o(bus_valid),
    .busy_o(busy), .done_o(done), .err_timeout_o(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer a command for one cycle; the following negedge is REQ cycle 0.
  task automatic accept(input logic [LEN_W-1:0] len);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_len = len; gnt = 1'b0; src_valid = 1'b0;
    #1 chk("accept_ready", cmd_ready, 1'b1);
    @(posedge clk);
  endtask

  // Drive gnt/src_valid per-cycle patterns (bit i = cycle i after acceptance)
  // and record what the bus does until the agent is back in IDLE.
  task automatic run_burst(input logic [63:0] gp, input logic [63:0] sp,
                           output int nb, output int nd, output int dbeat,
                           output int fcyc, output int lcyc, output int nrel,
                           output int viol, output int derr, output int ok);
    nb = 0; nd = 0; dbeat = -1; fcyc = -1; lcyc = -1; nrel = 0; viol = 0; derr = 0; ok = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0; cmd_len = 8'h00;  // late length change must be ignored
      gnt = gp[i]; src_valid = sp[i]; src_data = 32'hA000 + 32'(nb);
      #1;
      if (bus_valid) begin
        if (bus_data !== 32'hA000 + 32'(nb)) derr++;
        if (nb == 0) fcyc = i;
        lcyc = i;
        nb++;
      end
      if (done) begin nd++; dbeat = nb; end
      if (done && !bus_valid) viol++;
      if (bus_valid && !(gnt && src_valid && req)) viol++;
      if (src_ready && !(gnt && req)) viol++;
      if (busy && cmd_ready) viol++;
      if (busy && !req) nrel++;
      if (!busy) begin ok = 1; break; end
    end
    gnt = 1'b0; src_valid = 1'b0;
  endtask

  int nb, nd, dbeat, fcyc, lcyc, nrel, viol, derr, ok, bad;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; gnt = 1'b0;
    src_valid = 1'b0; src_data = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_req", req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bus_valid", bus_valid, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    // Spurious grant in IDLE must not move data
    gnt = 1'b1; src_valid = 1'b1;
    #1;
    chk("idle_cmd_ready", cmd_ready, 1'b1);
    chk("idle_spurious_gnt_bv", bus_valid, 1'b0);
    chk("idle_spurious_gnt_srdy", src_ready, 1'b0);

    // 1: len 3, gnt one cycle after req, source always valid
    accept(8'd3);
    run_burst(64'hFFFF_FFFF_FFFF_FFFE, '1, nb, nd, dbeat, fcyc, lcyc, nrel, viol, derr, ok);
    chk("t1_end", ok, 1); chk("t1_beats", nb, 4); chk("t1_done", nd, 1);
    chk("t1_done_beat", dbeat, 4); chk("t1_first", fcyc, 2); chk("t1_last", lcyc, 5);
    chk("t1_rel", nrel, 1); chk("t1_viol", viol, 0); chk("t1_data", derr, 0);

    // 2: single beat
    accept(8'd0);
    run_burst(64'hFFFF_FFFF_FFFF_FFFE, '1, nb, nd, dbeat, fcyc, lcyc, nrel, viol, derr, ok);
    chk("t2_end", ok, 1); chk("t2_beats", nb, 1); chk("t2_done_beat", dbeat, 1);
    chk("t2_last", lcyc, 2); chk("t2_rel", nrel, 1); chk("t2_viol", viol, 0);

    // 3: len 5, grant lost for 3 cycles after beat 2 (cycles 4..6)
    accept(8'd5);
    run_burst(64'hFFFF_FFFF_FFFF_FF8E, '1, nb, nd, dbeat, fcyc, lcyc, nrel, viol, derr, ok);
    chk("t3_end", ok, 1); chk("t3_beats", nb, 6); chk("t3_done_beat", dbeat, 6);
    chk("t3_last", lcyc, 10); chk("t3_viol", viol, 0); chk("t3_data", derr, 0);

    // 4: source valid every other cycle
    accept(8'd3);
    run_burst(64'hFFFF_FFFF_FFFF_FFFE, 64'h5555_5555_5555_5555, nb, nd, dbeat, fcyc, lcyc, nrel, viol, derr, ok);
    chk("t4_end", ok, 1); chk("t4_beats", nb, 4); chk("t4_done_beat", dbeat, 4);
    chk("t4_last", lcyc, 8); chk("t4_viol", viol, 0); chk("t4_data", derr, 0);

`ifdef BUS_REQ_TIMEOUT_EN
    // 5a: no grant -> abort on the 8th REQ cycle
    accept(8'd0);
    for (int i = 0; i < TOC; i++) begin
      @(negedge clk); cmd_valid = 1'b0; gnt = 1'b0; src_valid = 1'b1;
      #1;
      chk("t5_err", err_timeout, (i == TOC - 1));
      chk("t5_req", req, 1'b1);
    end
    @(negedge clk); #1;
    chk("t5_req_drop", req, 1'b0); chk("t5_idle", busy, 1'b0); chk("t5_cmd_ready", cmd_ready, 1'b1);
    // 5b: grant arrives on the terminal cycle -> no error, burst proceeds
    accept(8'd0);
    for (int i = 0; i < TOC; i++) begin
      @(negedge clk); cmd_valid = 1'b0; gnt = (i == TOC - 1); src_valid = 1'b1;
      #1;
      chk("t5b_err", err_timeout, 1'b0);
    end
    @(negedge clk); #1;
    chk("t5b_beat", bus_valid, 1'b1); chk("t5b_done", done, 1'b1);
    @(negedge clk); gnt = 1'b0; #1;
    chk("t5b_rel", busy & ~req, 1'b1);
    @(negedge clk); #1;
    chk("t5b_idle", busy, 1'b0);
`else
    // 5: no watchdog -> REQ waits indefinitely, err_timeout stays 0
    accept(8'd0);
    bad = 0;
    for (int i = 0; i < 3 * TOC; i++) begin
      @(negedge clk); cmd_valid = 1'b0; gnt = 1'b0; src_valid = 1'b1;
      #1;
      if (err_timeout || !req || bus_valid) bad++;
    end
    chk("t5_no_wdog", bad, 0);
    run_burst('1, '1, nb, nd, dbeat, fcyc, lcyc, nrel, viol, derr, ok);
    chk("t5_end", ok, 1); chk("t5_beats", nb, 1); chk("t5_first", fcyc, 1);
`endif

    // 6: reset in the middle of a 4-beat burst, after beat 2
    accept(8'd3);
    nb = 0;
    for (int i = 0; i < 16 && nb < 2; i++) begin
      @(negedge clk); cmd_valid = 1'b0; gnt = 1'b1; src_valid = 1'b1;
      #1;
      if (bus_valid) nb++;
    end
    chk("t6_two_beats", nb, 2);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("t6_req", req, 1'b0); chk("t6_bus_valid", bus_valid, 1'b0);
    chk("t6_busy", busy, 1'b0); chk("t6_cmd_ready", cmd_ready, 1'b0);
    @(negedge clk); rst_n = 1'b1; gnt = 1'b0;
    #1;
    chk("t6_cmd_ready_after", cmd_ready, 1'b1); chk("t6_idle", busy, 1'b0);
    accept(8'd1);
    run_burst(64'hFFFF_FFFF_FFFF_FFFE, '1, nb, nd, dbeat, fcyc, lcyc, nrel, viol, derr, ok);
    chk("t6_recover_beats", nb, 2); chk("t6_recover_done", dbeat, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
